// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and
// read-latency counter width.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// whichever master was not granted last.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // NOTE: every output is assigned on every path through always_comb, so no
  // latch can be inferred.
  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU
// (master 0) and the DMA engine (master 1); all memory-side outputs registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = 20,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_data,
  input  logic          m0_we,
  output logic          m0_ack,
  output logic [DW-1:0] m0_q,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_data,
  input  logic          m1_we,
  output logic          m1_ack,
  output logic [DW-1:0] m1_q,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          owner
);

  localparam logic [CNT_W-1:0] LP_LAT = CNT_W'(RD_LAT);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_m0_ack;
  logic               r_m1_ack;
  logic [DW-1:0]      r_m0_q;
  logic [DW-1:0]      r_m1_q;
  logic [AW-1:0]      r_mem_address;
  logic [DW-1:0]      r_mem_data;
  logic               r_mem_wren;
  logic               r_busy;
  logic               r_owner;

  logic               w_gnt;
  logic               w_valid;

  rr_pick u_rr_pick (
    .req   ({m1_req, m0_req}),
    .last  (r_owner),
    .gnt   (w_gnt),
    .valid (w_valid)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_m0_ack      <= 1'b0;
      r_m1_ack      <= 1'b0;
      r_m0_q        <= '0;
      r_m1_q        <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_busy        <= 1'b0;
      r_owner       <= 1'b1;
    end else begin
      // Acks and the write strobe are single-cycle pulses.
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_mem_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_mem_address <= w_gnt ? m1_address : m0_address;
            r_mem_data    <= w_gnt ? m1_data    : m0_data;
            r_mem_wren    <= w_gnt ? m1_we      : m0_we;
            r_owner       <= w_gnt;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The write strobe doubles as the record of the granted access type.
          if (r_mem_wren) begin
            r_m0_ack <= ~r_owner;
            r_m1_ack <= r_owner;
            r_state  <= S_DONE;
          end else begin
            r_cnt   <= LP_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            if (r_owner) r_m1_q <= mem_q;
            else         r_m0_q <= mem_q;
            r_m0_ack <= ~r_owner;
            r_m1_ack <= r_owner;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_ack      = r_m0_ack;
  assign m1_ack      = r_m1_ack;
  assign m0_q        = r_m0_q;
  assign m1_q        = r_m1_q;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign busy        = r_busy;
  assign owner       = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every
// cycle on an RD_LAT=1 instance, plus directed literal checks on RD_LAT=1 and 3.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          resetn;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance A: RD_LAT = 1 ----------------
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_data, m1_data;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_q, m1_q;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren, busy, owner;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
    .clock(clock), .resetn(resetn),
    .m0_req(m0_req), .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_q(m0_q),
    .m1_req(m1_req), .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_q(m1_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  // ---------------- instance B: RD_LAT = 3 ----------------
  logic          b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [AW-1:0] b_m0_address, b_m1_address;
  logic [DW-1:0] b_m0_data, b_m1_data;
  logic          b_m0_ack, b_m1_ack;
  logic [DW-1:0] b_m0_q, b_m1_q;
  logic [AW-1:0] b_mem_address;
  logic [DW-1:0] b_mem_data, b_mem_q;
  logic          b_mem_wren, b_busy, b_owner;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clock(clock), .resetn(resetn),
    .m0_req(b_m0_req), .m0_address(b_m0_address), .m0_data(b_m0_data), .m0_we(b_m0_we),
    .m0_ack(b_m0_ack), .m0_q(b_m0_q),
    .m1_req(b_m1_req), .m1_address(b_m1_address), .m1_data(b_m1_data), .m1_we(b_m1_we),
    .m1_ack(b_m1_ack), .m1_q(b_m1_q),
    .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
    .mem_q(b_mem_q), .busy(b_busy), .owner(b_owner)
  );

  // ---------------- memory models ----------------
  // Unwritten locations hold addr[7:0]^0x79 (so 0x00123 reads 0x5A). Read data
  // is driven only in the one cycle it is due; 0xEE otherwise, so an early or
  // late capture is visible.
  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h79;
  endfunction

  logic [7:0] ram_a [int];
  function automatic logic [7:0] rd_a(input logic [AW-1:0] a);
    if (ram_a.exists(int'(a))) return ram_a[int'(a)];
    return init_val(a);
  endfunction

  bit         a_v, a_prev_busy;
  logic [7:0] a_d = 8'h00;
  always @(posedge clock) begin
    a_v         <= busy && !a_prev_busy;
    a_d         <= rd_a(mem_address);
    a_prev_busy <= busy;
    if (mem_wren) ram_a[int'(mem_address)] = mem_data;
  end
  assign mem_q = a_v ? a_d : 8'hEE;

  bit   [2:0] b_v;
  bit         b_prev_busy;
  logic [7:0] b_d [3];
  always @(posedge clock) begin
    b_v         <= {b_v[1:0], b_busy && !b_prev_busy};
    b_d[0]      <= init_val(b_mem_address);
    b_d[1]      <= b_d[0];
    b_d[2]      <= b_d[1];
    b_prev_busy <= b_busy;
  end
  assign b_mem_q = b_v[2] ? b_d[2] : 8'hEE;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of instance A ----------------
  // An access granted in an idle cycle (t=0) occupies t=1..dur-1 and acks at
  // t=dur-1, where dur is 3 for a write and RD_LAT+3 for a read.
  bit          md_active, md_g, md_we, md_owner;
  int          md_t, md_dur;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_data;
  logic [DW-1:0] md_q [2];
  logic [DW-1:0] ref_mem [int];
  logic [1:0]  e_ack;
  logic        e_wren;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  always @(negedge clock) begin
    if (!resetn) begin
      md_active = 1'b0;
      md_owner  = 1'b1;
      md_q[0]   = '0;
      md_q[1]   = '0;
      md_addr   = '0;
      md_data   = '0;
    end
    e_ack  = 2'b00;
    e_wren = 1'b0;
    if (md_active) begin
      e_wren = md_we && (md_t == 1);
      if (md_t == md_dur - 1) begin
        e_ack[md_g] = 1'b1;
        if (!md_we) md_q[md_g] = ref_rd(md_addr);
      end
    end
    check("model busy",     32'(busy),        32'(md_active));
    check("model owner",    32'(owner),       32'(md_owner));
    check("model m0_ack",   32'(m0_ack),      32'(e_ack[0]));
    check("model m1_ack",   32'(m1_ack),      32'(e_ack[1]));
    check("model mem_wren", 32'(mem_wren),    32'(e_wren));
    check("model mem_addr", 32'(mem_address), 32'(md_addr));
    check("model mem_data", 32'(mem_data),    32'(md_data));
    check("model m0_q",     32'(m0_q),        32'(md_q[0]));
    check("model m1_q",     32'(m1_q),        32'(md_q[1]));
    if (resetn) begin
      if (md_active) begin
        md_t++;
        if (md_t == md_dur) md_active = 1'b0;
      end else if (m0_req || m1_req) begin
        md_g      = (m0_req && m1_req) ? !md_owner : m1_req;
        md_we     = md_g ? m1_we      : m0_we;
        md_addr   = md_g ? m1_address : m0_address;
        md_data   = md_g ? m1_data    : m0_data;
        md_owner  = md_g;
        md_dur    = md_we ? 3 : 1 + 3;
        md_t      = 1;
        md_active = 1'b1;
        if (md_we) ref_mem[int'(md_addr)] = md_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // sel: 0 = A.m0, 1 = A.m1, 2 = B.m0. Returns the cycle number of the ack.
  task automatic wait_ack(input int sel, input string name, output int at);
    at = -1;
    for (int k = 0; k < 30 && at < 0; k++) begin
      tick(1);
      if ((sel == 0 && m0_ack) || (sel == 1 && m1_ack) || (sel == 2 && b_m0_ack)) at = cyc;
    end
    check({name, " ack seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    m0_req   = 1'b0;
    m1_req   = 1'b0;
    b_m0_req = 1'b0;
    b_m1_req = 1'b0;
    tick(2);
    check("reset busy",   32'(busy),        32'd0);
    check("reset owner",  32'(owner),       32'd1);
    check("reset m0_q",   32'(m0_q),        32'd0);
    check("reset addr",   32'(mem_address), 32'd0);
    check("reset wren",   32'(mem_wren),    32'd0);
    check("reset b_q",    32'(b_m0_q),      32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, at, c1, c2, who;
    resetn     = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_address = '0; m0_data = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_address = '0; m1_data = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_address = '0; b_m0_data = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_address = '0; b_m1_data = '0;
    do_reset();

    // CPU read at 0x00123 -> 0x5A, ack in cycle 3.
    m0_address = 20'h00123; m0_we = 1'b0; m0_data = 8'h11; m0_req = 1'b1;
    t0 = cyc;
    tick(1);
    check("t1 mem_address c1", 32'(mem_address), 32'h00123);
    check("t1 busy c1",        32'(busy),        32'd1);
    wait_ack(0, "t1", at);
    check("t1 ack cycle",      32'(at - t0),     32'd3);
    check("t1 m0_q",           32'(m0_q),        32'h5A);
    check("t1 m1_ack",         32'(m1_ack),      32'd0);
    m0_req = 1'b0;
    tick(1);
    check("t1 m0_q held",      32'(m0_q),        32'h5A);

    // DMA write of 0xC3 to 0x3FFFF, ack in cycle 2.
    m1_address = 20'h3FFFF; m1_we = 1'b1; m1_data = 8'hC3; m1_req = 1'b1;
    tick(1);
    check("t2 wren c1",        32'(mem_wren),    32'd1);
    check("t2 mem_data",       32'(mem_data),    32'hC3);
    check("t2 mem_address",    32'(mem_address), 32'h3FFFF);
    tick(1);
    check("t2 wren c2",        32'(mem_wren),    32'd0);
    check("t2 m1_ack c2",      32'(m1_ack),      32'd1);
    check("t2 m1_q unchanged", 32'(m1_q),        32'd0);
    m1_req = 1'b0;
    tick(1);
    // DMA reads the location back.
    m1_we = 1'b0; m1_req = 1'b1;
    wait_ack(1, "t2 readback", at);
    check("t2 readback m1_q",  32'(m1_q),        32'hC3);
    m1_req = 1'b0;
    tick(1);

    // Both masters request continuously: grants alternate starting with CPU.
    do_reset();
    m0_address = 20'h00010; m0_we = 1'b0; m0_req = 1'b1;
    m1_address = 20'h00020; m1_we = 1'b1; m1_data = 8'h77; m1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      who = -1;
      for (int k = 0; k < 10 && who < 0; k++) begin
        tick(1);
        if (m0_ack || m1_ack) who = m1_ack ? 1 : 0;
      end
      check($sformatf("t3 grant %0d", i), 32'(who), 32'(i % 2));
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(1);

    // RD_LAT=3 instance: CPU read acks in cycle 5 with the data due exactly
    // three edges after the ISSUE edge.
    b_m0_address = 20'h00123; b_m0_we = 1'b0; b_m0_data = 8'h3C; b_m0_req = 1'b1;
    t0 = cyc;
    tick(1);
    check("t4 b mem_data",     32'(b_mem_data),  32'h3C);
    wait_ack(2, "t4", at);
    check("t4 ack cycle",      32'(at - t0),     32'd5);
    check("t4 b_m0_q",         32'(b_m0_q),      32'h5A);
    check("t4 b_m1_ack",       32'(b_m1_ack),    32'd0);
    check("t4 b_mem_wren",     32'(b_mem_wren),  32'd0);
    check("t4 b_owner",        32'(b_owner),     32'd0);
    check("t4 b_m1_q",         32'(b_m1_q),      32'd0);
    b_m0_req = 1'b0;
    tick(1);

    // DMA read of the value written above, then reset during a second DMA read.
    m1_address = 20'h00020; m1_we = 1'b0; m1_req = 1'b1;
    wait_ack(1, "t5 pre", at);
    check("t5 pre m1_q",       32'(m1_q),        32'h77);
    m1_req = 1'b0;
    tick(1);
    m1_address = 20'h00400; m1_req = 1'b1;
    tick(2);
    resetn = 1'b0; m1_req = 1'b0;
    #1;
    check("t5 busy",           32'(busy),        32'd0);
    check("t5 m1_q",           32'(m1_q),        32'd0);
    check("t5 owner",          32'(owner),       32'd1);
    check("t5 wren",           32'(mem_wren),    32'd0);
    tick(1);
    check("t5 no m1_ack",      32'(m1_ack),      32'd0);
    resetn = 1'b1;
    m0_address = 20'h00123; m0_we = 1'b0; m0_req = 1'b1;
    t0 = cyc;
    wait_ack(0, "t5 post", at);
    check("t5 post latency",   32'(at - t0),     32'd3);
    check("t5 post m0_q",      32'(m0_q),        32'h5A);
    m0_req = 1'b0;
    tick(1);

    // CPU holds req across its ack: back-to-back reads, acks RD_LAT+3 apart.
    m0_address = 20'h00055; m0_we = 1'b0; m0_req = 1'b1;
    wait_ack(0, "t6 first", c1);
    tick(1);
    check("t6 idle ack",       32'(m0_ack),      32'd0);
    check("t6 idle busy",      32'(busy),        32'd0);
    wait_ack(0, "t6 second", c2);
    check("t6 ack spacing",    32'(c2 - c1),     32'd4);
    check("t6 m0_q",           32'(m0_q),        32'h2C);
    m0_req = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port 256 KB main `memory` block between the `core88` CPU (master 0) and an SD-to-RAM DMA engine (master 1). It sits between the requesters and the memory routing logic in the `de0` top level. It serialises accesses with round-robin fairness, drives the memory address, data and write-enable from registers, and returns read data with a per-master one-cycle acknowledge.

## Interface
Parameters:
- `AW`, 20: address width.
- `DW`, 8: data width.
- `RD_LAT`, 1: memory read latency in clocks, counted from the edge that samples the address to the edge where `mem_q` is valid. Range 1..7.

Ports:
- `clock`  in  1  single clock for all logic.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  CPU request; level, held until `m0_ack`.
- `m0_address`  in  AW  CPU address; stable while `m0_req` is high.
- `m0_data`  in  DW  CPU write data.
- `m0_we`  in  1  CPU write (1) or read (0).
- `m0_ack`  out  1  one-cycle completion pulse.
- `m0_q`  out  DW  CPU read data; valid in the `m0_ack` cycle and held until the next `m0_ack`.
- `m1_req`, `m1_address`, `m1_data`, `m1_we`, `m1_ack`, `m1_q`: identical set for the DMA master.
- `mem_address`  out  AW  registered memory address.
- `mem_data`  out  DW  registered memory write data.
- `mem_wren`  out  1  registered write enable; high for exactly one cycle per write.
- `mem_q`  in  DW  memory read data.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  master currently or most recently granted.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant the master that is not `owner` (round-robin).
  - On grant, register `mem_address`, `mem_data` and `mem_wren = mX_we`, set `owner`, and go to ISSUE.
- ISSUE:
  - Write: go to DONE. `mem_wren` falls on that edge.
  - Read: load the wait counter with `RD_LAT` and go to WAIT.
- WAIT: decrement the counter each edge. On the edge where the counter equals 1, capture `mem_q` into `m<owner>_q` and go to DONE.
- DONE:
  - Assert `m<owner>_ack` for exactly this cycle.
  - Do not sample requests in this cycle.
  - Go to IDLE on the next edge.
  - A master that still holds `req` after its ack has made a new request.
- Write accesses leave `mX_q` unchanged.
- `mem_address` and `mem_data` hold their last values outside ISSUE. `mem_wren` is 0 in every state except ISSUE.
- A master must not change `address`, `we` or `data` while `req` is high. Behaviour when it does is undefined, except that the values sampled at grant are the ones used.

## Timing
- Reset values: state IDLE, all acks 0, `m0_q` = `m1_q` = 0, `mem_address` = 0, `mem_data` = 0, `mem_wren` = 0, `busy` = 0, `owner` = 1. With `owner` = 1, the CPU wins the first simultaneous request.
- Read latency: `req` is high in cycle 0 and the arbiter is idle. ISSUE occupies cycle 1, WAIT occupies cycles 2..1+RD_LAT, and ack arrives in cycle 2+RD_LAT. For RD_LAT=1 the ack is in cycle 3.
- Write latency: ack in cycle 2.
- Throughput per access: read RD_LAT+3 cycles, write 3 cycles, including the return to IDLE.
- Starvation bound: a waiting master is granted no later than after one access by the other master.
- Reset mid-operation: all registers clear asynchronously and the pending access is dropped with no ack. `mem_wren` drops immediately. A write is only committed if the memory had already sampled it.
- `owner` changes only on a grant edge.

## Structure
- Shared package `mem_arbiter_pkg`:
  - state encoding localparams `ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_DONE` (2 bits);
  - `RD_LAT` counter width (3 bits).
- One natural sub-module, `rr_pick`: combinational; inputs `req[1:0]` and `last`; outputs `gnt` and `valid`. Everything else is a single always block plus output registers.

## Test plan
- CPU read at 0x00123 with memory model returning 0x5A and RD_LAT=1 -> `mem_address` = 0x00123 in cycle 1, `m0_ack` in cycle 3, `m0_q` = 0x5A and held afterwards; `m1_ack` stays 0.
- DMA write of 0xC3 to 0x3FFFF -> `mem_wren` = 1 only in cycle 1, `mem_data` = 0xC3, `m1_ack` in cycle 2, `m1_q` unchanged.
- Both masters request continuously after reset -> grants alternate 0,1,0,1 for 8 accesses; each ack goes to the matching master; `owner` toggles.
- RD_LAT=3 build, CPU read -> ack in cycle 5; data is captured from `mem_q` exactly 3 edges after the ISSUE edge.
- `resetn` pulsed low during WAIT of a DMA read -> no `m1_ack`, `busy` = 0, `m1_q` = 0, `owner` = 1. A following CPU read completes normally.
- CPU holds `req` across its ack with the DMA idle -> second access starts in the IDLE cycle after DONE, and its ack arrives RD_LAT+3 cycles after the first ack.
